// File: rtl/bcd_conv_sequencer_if.sv
// Result-path handshake bundle for the binary-to-BCD sequencer.
// Input word side: i_valid/o_ready/i_bin/i_sign; result side: o_valid/i_ready/o_bcd/o_negative.
interface bcd_conv_sequencer_if #(
    parameter int NB_DATA = 8,
    parameter int NB_BCD  = 12
);
    logic               i_valid;
    logic               o_ready;
    logic [NB_DATA-1:0] i_bin;
    logic               i_sign;
    logic               o_valid;
    logic               i_ready;
    logic [NB_BCD-1:0]  o_bcd;
    logic               o_negative;

    modport master (
        output i_valid, i_bin, i_sign, i_ready,
        input  o_ready, o_valid, o_bcd, o_negative
    );

    modport slave (
        input  i_valid, i_bin, i_sign, i_ready,
        output o_ready, o_valid, o_bcd, o_negative
    );
endinterface

// File: rtl/bcd_conv_sequencer.sv
// Multi-cycle Double Dabble binary-to-BCD converter, one shift per clock.
// Ports: i_clk, i_rst_n (async low), i_clear (sync abort), o_busy, bus (slave handshake).
module bcd_conv_sequencer #(
    parameter int NB_DATA = 8,
    parameter int NB_BCD  = 12,
    parameter int NB_CNT  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    output logic                 o_busy,
    bcd_conv_sequencer_if.slave  bus
);
    localparam int NB_SR = NB_BCD + NB_DATA;
    localparam int NDIG  = NB_BCD / 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NB_SR-1:0]   sr_q, sr_d;
    logic [NB_SR-1:0]   sr_adj, sr_shl;
    logic [NB_CNT-1:0]  cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [NB_BCD-1:0]  bcd_q, bcd_d;
    logic               nout_q, nout_d;
    logic               in_neg;
    logic [NB_DATA-1:0] mag;

    // Signed 0x80 negates to itself and reads back as 128 unsigned.
    assign in_neg = bus.i_sign & bus.i_bin[NB_DATA-1];
    assign mag    = in_neg ? -bus.i_bin : bus.i_bin;

    // Add-3 on every BCD digit >= 5, then shift left one.
    always_comb begin
        sr_adj = sr_q;
        for (int d = 0; d < NDIG; d++) begin
            if (sr_q[NB_DATA+4*d +: 4] >= 4'd5)
                sr_adj[NB_DATA+4*d +: 4] = sr_q[NB_DATA+4*d +: 4] + 4'd3;
        end
        sr_shl = sr_adj << 1;
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        bcd_d   = bcd_q;
        nout_d  = nout_q;
        if (i_clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.i_valid) begin
                        sr_d    = {{NB_BCD{1'b0}}, mag};
                        neg_d   = in_neg;
                        cnt_d   = NB_CNT'(NB_DATA);
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    sr_d  = sr_shl;
                    cnt_d = cnt_q - NB_CNT'(1);
                    if (cnt_q == NB_CNT'(1)) begin
                        bcd_d   = sr_shl[NB_SR-1 -: NB_BCD];
                        nout_d  = neg_q;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (bus.i_ready)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            bcd_q   <= '0;
            nout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            bcd_q   <= bcd_d;
            nout_q  <= nout_d;
        end
    end

    assign bus.o_ready    = (state_q == IDLE);
    assign bus.o_valid    = (state_q == DONE);
    assign o_busy         = (state_q == SHIFT);
    assign bus.o_bcd      = bcd_q;
    assign bus.o_negative = nout_q;
endmodule
